// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
//
// Serial receiver and checker for parity-protected frames. A frame begins
// with a one-cycle start strobe, followed by DATA_BITS data bits (MSB first)
// and one trailing parity bit. Each bit is taken on a clock edge where
// i_bit_valid is high. Once the parity bit arrives, the captured word and
// the parity check result are presented for one cycle. Parity failures are
// counted in a saturating 8-bit counter. If the line goes quiet for too long
// in the middle of a frame, the partial frame is dropped.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        one-cycle frame-start strobe, honoured only when idle
//   i_bit_in       serial data/parity bit
//   i_bit_valid    qualifies i_bit_in on this clock edge
//   o_data_out     last complete data word (first received bit = MSB)
//   o_data_valid   one-cycle pulse when a complete frame is available
//   o_parity_err   one-cycle pulse with o_data_valid when parity fails
//   o_frame_abort  one-cycle pulse when a frame is dropped on timeout
//   o_busy         high while a frame is being received or presented
//   o_err_count    saturating count of parity errors
// ---------------------------------------------------------------------------
module parity_frame_rx #(
  parameter int DATA_BITS   = 3,
  parameter bit ODD_PARITY  = 1'b1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_bit_in,
  input  logic                 i_bit_valid,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_abort,
  output logic                 o_busy,
  output logic [7:0]           o_err_count
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_PARITY,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]       r_bitCnt;
  logic [TCW-1:0]       r_toCnt;

  logic [DATA_BITS-1:0] w_shiftNext;
  logic                 w_parityErr;
  logic                 w_toExpire;

  // Next shift register value: the new bit enters at the LSB so the first
  // bit of the frame ends up at the MSB. Written as shift-then-patch so it
  // still works when DATA_BITS is 1.
  always_comb begin
    w_shiftNext    = r_shift << 1;
    w_shiftNext[0] = i_bit_in;
  end

  // XOR of data and parity is 1 when the total count of ones is odd; the
  // frame is bad when that disagrees with the expected parity sense.
  assign w_parityErr = (^r_shift) ^ i_bit_in ^ ODD_PARITY;

  // True on the idle cycle that would bring the gap counter to TIMEOUT_CYC.
  assign w_toExpire = (r_toCnt == TCW'(TIMEOUT_CYC - 1));

  // Single receive FSM. Every output is a register; the pulse outputs are
  // cleared each cycle and only set on the edge that enters the state in
  // which they must be seen, so they can never stay high two cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bitCnt      <= '0;
      r_toCnt       <= '0;
      o_data_out    <= '0;
      o_data_valid  <= 1'b0;
      o_parity_err  <= 1'b0;
      o_frame_abort <= 1'b0;
      o_busy        <= 1'b0;
      o_err_count   <= 8'd0;
    end else begin
      o_data_valid  <= 1'b0;
      o_parity_err  <= 1'b0;
      o_frame_abort <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Bits arriving while idle are ignored, even alongside start.
          if (i_start) begin
            r_state  <= S_RECV;
            o_busy   <= 1'b1;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_toCnt  <= '0;
          end
        end

        S_RECV: begin
          // An arriving bit beats a timeout landing on the same cycle.
          if (i_bit_valid) begin
            r_shift  <= w_shiftNext;
            r_bitCnt <= r_bitCnt + 1'b1;
            r_toCnt  <= '0;
            if (r_bitCnt == BCW'(DATA_BITS - 1)) begin
              r_state <= S_PARITY;
            end
          end else if (w_toExpire) begin
            r_state       <= S_IDLE;
            o_busy        <= 1'b0;
            o_frame_abort <= 1'b1;
            r_toCnt       <= '0;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end

        S_PARITY: begin
          // The parity bit completes the frame: present the word and the
          // check result during the following (DONE) cycle.
          if (i_bit_valid) begin
            r_state      <= S_DONE;
            r_toCnt      <= '0;
            o_data_out   <= r_shift;
            o_data_valid <= 1'b1;
            o_parity_err <= w_parityErr;
            if (w_parityErr && (o_err_count != 8'hFF)) begin
              o_err_count <= o_err_count + 8'd1;
            end
          end else if (w_toExpire) begin
            r_state       <= S_IDLE;
            o_busy        <= 1'b0;
            o_frame_abort <= 1'b1;
            r_toCnt       <= '0;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end

        S_DONE: begin
          // Start is not looked at here; a new frame waits for IDLE.
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_rx
//
// Directed bench for parity_frame_rx with the default parameters (3 data
// bits, odd parity, 16-cycle timeout). Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so each sample shows the
// registers updated by the edge just passed.
// ---------------------------------------------------------------------------
module tb_parity_frame_rx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bitIn;
  logic       bitValid;
  logic [2:0] dataOut;
  logic       dataValid;
  logic       parityErr;
  logic       frameAbort;
  logic       busy;
  logic [7:0] errCount;

  int total;
  int bad;

  parity_frame_rx #(
    .DATA_BITS  (3),
    .ODD_PARITY (1'b1),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_bit_in     (bitIn),
    .i_bit_valid  (bitValid),
    .o_data_out   (dataOut),
    .o_data_valid (dataValid),
    .o_parity_err (parityErr),
    .o_frame_abort(frameAbort),
    .o_busy       (busy),
    .o_err_count  (errCount)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    bitIn    = b;
    bitValid = 1'b1;
    tick();
    bitValid = 1'b0;
    bitIn    = 1'b0;
  endtask

  // Start, three data bits MSB first, then parity. Returns in the DONE cycle.
  task automatic sendFrame(input logic [2:0] d, input logic p);
    pulseStart();
    sendBit(d[2]);
    sendBit(d[1]);
    sendBit(d[0]);
    sendBit(p);
  endtask

  // Reset held for two edges clears every output.
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total++; if (dataOut !== 3'b000) begin bad++; $display("[TB] FAIL reset_data got=%b want=000", dataOut); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", dataValid); end
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%b want=0", parityErr); end
    total++; if (frameAbort !== 1'b0) begin bad++; $display("[TB] FAIL reset_abort got=%b want=0", frameAbort); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (errCount !== 8'd0) begin bad++; $display("[TB] FAIL reset_errcnt got=%0d want=0", errCount); end
    rst = 1'b0;
    tick();
  endtask

  // All eight words with correct odd parity (XNOR of the data bits).
  task automatic test_good_frames();
    logic [7:0] parTab;
    logic [2:0] d;
    parTab = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      d = 3'(i);
      sendFrame(d, parTab[i]);
      total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL good_valid[%0d] got=%b want=1", i, dataValid); end
      total++; if (dataOut !== d) begin bad++; $display("[TB] FAIL good_data[%0d] got=%b want=%b", i, dataOut, d); end
      total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL good_perr[%0d] got=%b want=0", i, parityErr); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL good_busy_done[%0d] got=%b want=1", i, busy); end
      total++; if (errCount !== 8'd0) begin bad++; $display("[TB] FAIL good_errcnt[%0d] got=%0d want=0", i, errCount); end
      tick();
      total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL good_pulse[%0d] got=%b want=0", i, dataValid); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL good_busy_idle[%0d] got=%b want=0", i, busy); end
    end
  endtask

  // Five idle cycles between the first two bits do not disturb the frame.
  task automatic test_gapped();
    pulseStart();
    sendBit(1'b1);
    idle(5);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid got=%b want=1", dataValid); end
    total++; if (dataOut !== 3'b101) begin bad++; $display("[TB] FAIL gap_data got=%b want=101", dataOut); end
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL gap_perr got=%b want=0", parityErr); end
    tick();
  endtask

  // Sixteen quiet cycles after a bit abort the frame; fifteen do not.
  task automatic test_timeout();
    pulseStart();
    sendBit(1'b1);
    idle(15);
    total++; if (frameAbort !== 1'b0) begin bad++; $display("[TB] FAIL to_early_abort got=%b want=0", frameAbort); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL to_early_busy got=%b want=1", busy); end
    tick();
    total++; if (frameAbort !== 1'b1) begin bad++; $display("[TB] FAIL to_abort got=%b want=1", frameAbort); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL to_busy got=%b want=0", busy); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL to_valid got=%b want=0", dataValid); end
    total++; if (dataOut !== 3'b101) begin bad++; $display("[TB] FAIL to_data_hold got=%b want=101", dataOut); end
    tick();
    total++; if (frameAbort !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse got=%b want=0", frameAbort); end

    // A bit landing on the 16th quiet cycle is taken instead of aborting.
    pulseStart();
    sendBit(1'b0);
    idle(15);
    sendBit(1'b1);
    total++; if (frameAbort !== 1'b0) begin bad++; $display("[TB] FAIL to_race_abort got=%b want=0", frameAbort); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL to_race_busy got=%b want=1", busy); end
    idle(15);
    sendBit(1'b1);
    idle(15);
    sendBit(1'b1);
    total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL to_race_valid got=%b want=1", dataValid); end
    total++; if (dataOut !== 3'b011) begin bad++; $display("[TB] FAIL to_race_data got=%b want=011", dataOut); end
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL to_race_perr got=%b want=0", parityErr); end
    tick();
  endtask

  // Reset in the middle of a frame leaves no stale bits behind.
  task automatic test_reset_midframe();
    pulseStart();
    sendBit(1'b1);
    sendBit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    total++; if (dataOut !== 3'b000) begin bad++; $display("[TB] FAIL mid_data got=%b want=000", dataOut); end
    sendFrame(3'b011, 1'b1);
    total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL mid_valid got=%b want=1", dataValid); end
    total++; if (dataOut !== 3'b011) begin bad++; $display("[TB] FAIL mid_after_data got=%b want=011", dataOut); end
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL mid_perr got=%b want=0", parityErr); end
    tick();
  endtask

  // Bits while idle, a bit alongside start, start mid-frame and start in
  // the DONE cycle must all be ignored.
  task automatic test_ignored();
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_idle_busy got=%b want=0", busy); end
    total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL ign_idle_valid got=%b want=0", dataValid); end
    start    = 1'b1;
    bitIn    = 1'b1;
    bitValid = 1'b1;
    tick();
    start    = 1'b0;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    sendBit(1'b0);
    pulseStart();
    sendBit(1'b1);
    sendBit(1'b0);
    total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL ign_early_valid got=%b want=0", dataValid); end
    sendBit(1'b0);
    total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL ign_valid got=%b want=1", dataValid); end
    total++; if (dataOut !== 3'b010) begin bad++; $display("[TB] FAIL ign_data got=%b want=010", dataOut); end
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL ign_perr got=%b want=0", parityErr); end
    pulseStart();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_done_start got=%b want=0", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ign_done_start2 got=%b want=0", busy); end
  endtask

  // Data 101 with parity 0 has an even count of ones: an error every time.
  task automatic test_bad_parity();
    sendFrame(3'b101, 1'b0);
    total++; if (dataValid !== 1'b1) begin bad++; $display("[TB] FAIL bad_valid got=%b want=1", dataValid); end
    total++; if (dataOut !== 3'b101) begin bad++; $display("[TB] FAIL bad_data got=%b want=101", dataOut); end
    total++; if (parityErr !== 1'b1) begin bad++; $display("[TB] FAIL bad_perr got=%b want=1", parityErr); end
    total++; if (errCount !== 8'd1) begin bad++; $display("[TB] FAIL bad_errcnt got=%0d want=1", errCount); end
    tick();
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL bad_pulse got=%b want=0", parityErr); end
    for (int n = 2; n <= 300; n++) begin
      sendFrame(3'b101, 1'b0);
      if (n == 254) begin
        total++; if (errCount !== 8'd254) begin bad++; $display("[TB] FAIL sat_254 got=%0d want=254", errCount); end
      end
      if (n == 255 || n == 256 || n == 300) begin
        total++; if (errCount !== 8'd255) begin bad++; $display("[TB] FAIL sat_%0d got=%0d want=255", n, errCount); end
        total++; if (parityErr !== 1'b1) begin bad++; $display("[TB] FAIL sat_perr_%0d got=%b want=1", n, parityErr); end
      end
      tick();
    end
    sendFrame(3'b110, 1'b1);
    total++; if (parityErr !== 1'b0) begin bad++; $display("[TB] FAIL sat_good_perr got=%b want=0", parityErr); end
    total++; if (errCount !== 8'd255) begin bad++; $display("[TB] FAIL sat_good_errcnt got=%0d want=255", errCount); end
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bitIn    = 1'b0;
    bitValid = 1'b0;
    test_reset();
    test_good_frames();
    test_gapped();
    test_timeout();
    test_reset_midframe();
    test_ignored();
    test_bad_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
